// File: rtl/sc_scorecounter.sv
// sc_scorecounter
// Multi-digit BCD up/down score counter with edge-detected active-low
// requests, configurable upper bound, saturate-or-wrap behaviour and sticky
// overflow/underflow flags.
//
// Ports:
//   SC_SCORECOUNTER_CLOCK_50           system clock, rising edge
//   SC_SCORECOUNTER_RESET_InLow        synchronous reset, active-low
//   SC_SCORECOUNTER_upcount_InLow      increment request, counts on falling edge
//   SC_SCORECOUNTER_downcount_InLow    decrement request, counts on falling edge
//   SC_SCORECOUNTER_clear_InLow        synchronous clear, level-sensitive
//   SC_SCORECOUNTER_data_OutBUS        BCD value, units digit in [3:0]
//   SC_SCORECOUNTER_max_OutHigh        value == MAXVALUE
//   SC_SCORECOUNTER_zero_OutHigh       value == 0
//   SC_SCORECOUNTER_overflow_OutHigh   sticky: up event seen at MAXVALUE
//   SC_SCORECOUNTER_underflow_OutHigh  sticky: down event seen at 0
module sc_scorecounter #(
   parameter int unsigned SCORECOUNTER_DIGITS   = 2,
   parameter int unsigned SCORECOUNTER_MAXVALUE = 99,
   parameter bit          SCORECOUNTER_SATURATE = 1'b1
) (
   input  logic                               SC_SCORECOUNTER_CLOCK_50,
   input  logic                               SC_SCORECOUNTER_RESET_InLow,
   input  logic                               SC_SCORECOUNTER_upcount_InLow,
   input  logic                               SC_SCORECOUNTER_downcount_InLow,
   input  logic                               SC_SCORECOUNTER_clear_InLow,
   output logic [4*SCORECOUNTER_DIGITS-1:0]   SC_SCORECOUNTER_data_OutBUS,
   output logic                               SC_SCORECOUNTER_max_OutHigh,
   output logic                               SC_SCORECOUNTER_zero_OutHigh,
   output logic                               SC_SCORECOUNTER_overflow_OutHigh,
   output logic                               SC_SCORECOUNTER_underflow_OutHigh
);

   localparam int unsigned W = 4 * SCORECOUNTER_DIGITS;

   // Elaboration-time conversion of the decimal bound to its BCD pattern.
   function automatic logic [W-1:0] to_bcd(input int unsigned v);
      logic [W-1:0] r;
      int unsigned  t;
      r = '0;
      t = v;
      for (int unsigned i = 0; i < SCORECOUNTER_DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MAX_BCD = to_bcd(SCORECOUNTER_MAXVALUE);

   logic [W-1:0] value;
   logic [W-1:0] value_inc;
   logic [W-1:0] value_dec;
   logic         prev_up;
   logic         prev_down;
   logic         overflow;
   logic         underflow;
   logic         up_event;
   logic         down_event;
   logic         at_max;
   logic         at_zero;

   assign up_event   = prev_up   & ~SC_SCORECOUNTER_upcount_InLow;
   assign down_event = prev_down & ~SC_SCORECOUNTER_downcount_InLow;
   assign at_max     = (value == MAX_BCD);
   assign at_zero    = (value == '0);

   // Ripple BCD increment/decrement: a digit only moves while a carry/borrow
   // is still propagating from the units digit.
   always_comb begin
      logic       carry;
      logic       borrow;
      logic [3:0] dig;
      value_inc = value;
      value_dec = value;
      carry     = 1'b1;
      borrow    = 1'b1;
      for (int unsigned i = 0; i < SCORECOUNTER_DIGITS; i++) begin
         dig = value[4*i +: 4];
         if (carry) begin
            if (dig == 4'd9) begin
               value_inc[4*i +: 4] = 4'd0;
            end else begin
               value_inc[4*i +: 4] = dig + 4'd1;
               carry               = 1'b0;
            end
         end
         if (borrow) begin
            if (dig == 4'd0) begin
               value_dec[4*i +: 4] = 4'd9;
            end else begin
               value_dec[4*i +: 4] = dig - 4'd1;
               borrow              = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge SC_SCORECOUNTER_CLOCK_50) begin
      if (!SC_SCORECOUNTER_RESET_InLow) begin
         value     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         prev_up   <= 1'b1;
         prev_down <= 1'b1;
      end else begin
         // Edge history keeps tracking during clear so a request held
         // through clear does not fire again when clear is released.
         prev_up   <= SC_SCORECOUNTER_upcount_InLow;
         prev_down <= SC_SCORECOUNTER_downcount_InLow;
         if (!SC_SCORECOUNTER_clear_InLow) begin
            value     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else if (up_event && !down_event) begin
            if (!at_max) begin
               value <= value_inc;
            end else begin
               overflow <= 1'b1;
               if (!SCORECOUNTER_SATURATE) value <= '0;
            end
         end else if (down_event && !up_event) begin
            if (!at_zero) begin
               value <= value_dec;
            end else begin
               underflow <= 1'b1;
               if (!SCORECOUNTER_SATURATE) value <= MAX_BCD;
            end
         end
      end
   end

   assign SC_SCORECOUNTER_data_OutBUS       = value;
   assign SC_SCORECOUNTER_max_OutHigh       = at_max;
   assign SC_SCORECOUNTER_zero_OutHigh      = at_zero;
   assign SC_SCORECOUNTER_overflow_OutHigh  = overflow;
   assign SC_SCORECOUNTER_underflow_OutHigh = underflow;

endmodule

// File: tb/tb_sc_scorecounter.sv
// tb_sc_scorecounter
// Drives two counters from shared inputs: a saturating DIGITS=2/MAX=99 instance
// and a wrapping DIGITS=2/MAX=59 instance, and checks both against a decimal
// integer reference model of the counting rules.
module tb_sc_scorecounter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       up_n = 1'b1;
   logic       dn_n = 1'b1;
   logic       clr_n = 1'b1;

   logic [7:0] d0, d1;
   logic       mx0, z0, ov0, un0;
   logic       mx1, z1, ov1, un1;

   int         n_checks = 0;
   int         n_fail   = 0;

   // Reference model state: decimal values, flags, request history.
   int         mv  [2];
   bit         mov [2];
   bit         mun [2];
   bit         mpu, mpd;
   int         maxv[2] = '{99, 59};
   bit         msat[2] = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   sc_scorecounter #(
      .SCORECOUNTER_DIGITS  (2),
      .SCORECOUNTER_MAXVALUE(99),
      .SCORECOUNTER_SATURATE(1'b1)
   ) dut_sat (
      .SC_SCORECOUNTER_CLOCK_50         (clk),
      .SC_SCORECOUNTER_RESET_InLow      (rst_n),
      .SC_SCORECOUNTER_upcount_InLow    (up_n),
      .SC_SCORECOUNTER_downcount_InLow  (dn_n),
      .SC_SCORECOUNTER_clear_InLow      (clr_n),
      .SC_SCORECOUNTER_data_OutBUS      (d0),
      .SC_SCORECOUNTER_max_OutHigh      (mx0),
      .SC_SCORECOUNTER_zero_OutHigh     (z0),
      .SC_SCORECOUNTER_overflow_OutHigh (ov0),
      .SC_SCORECOUNTER_underflow_OutHigh(un0)
   );

   sc_scorecounter #(
      .SCORECOUNTER_DIGITS  (2),
      .SCORECOUNTER_MAXVALUE(59),
      .SCORECOUNTER_SATURATE(1'b0)
   ) dut_wrap (
      .SC_SCORECOUNTER_CLOCK_50         (clk),
      .SC_SCORECOUNTER_RESET_InLow      (rst_n),
      .SC_SCORECOUNTER_upcount_InLow    (up_n),
      .SC_SCORECOUNTER_downcount_InLow  (dn_n),
      .SC_SCORECOUNTER_clear_InLow      (clr_n),
      .SC_SCORECOUNTER_data_OutBUS      (d1),
      .SC_SCORECOUNTER_max_OutHigh      (mx1),
      .SC_SCORECOUNTER_zero_OutHigh     (z1),
      .SC_SCORECOUNTER_overflow_OutHigh (ov1),
      .SC_SCORECOUNTER_underflow_OutHigh(un1)
   );

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   // Expected {data, max, zero, overflow, underflow} for instance k.
   function automatic logic [11:0] expv(input int k);
      return {bcd(mv[k]), mv[k] == maxv[k], mv[k] == 0, mov[k], mun[k]};
   endfunction

   function automatic logic [11:0] obs(input int k);
      return (k == 0) ? {d0, mx0, z0, ov0, un0} : {d1, mx1, z1, ov1, un1};
   endfunction

   task automatic model_step();
      bit ue, de;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin mv[k] = 0; mov[k] = 0; mun[k] = 0; end
         mpu = 1; mpd = 1;
      end else begin
         ue = mpu && !up_n;
         de = mpd && !dn_n;
         mpu = up_n;
         mpd = dn_n;
         for (int k = 0; k < 2; k++) begin
            if (!clr_n) begin
               mv[k] = 0; mov[k] = 0; mun[k] = 0;
            end else if (ue && !de) begin
               if (mv[k] < maxv[k]) mv[k] = mv[k] + 1;
               else begin mov[k] = 1; if (!msat[k]) mv[k] = 0; end
            end else if (de && !ue) begin
               if (mv[k] > 0) mv[k] = mv[k] - 1;
               else begin mun[k] = 1; if (!msat[k]) mv[k] = maxv[k]; end
            end
         end
      end
   endtask

   // One rising edge; inputs are stable across it, outputs sampled 1 later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic pulse_up(input int n);
      for (int i = 0; i < n; i++) begin up_n = 0; tick(); up_n = 1; tick(); end
   endtask

   task automatic pulse_dn(input int n);
      for (int i = 0; i < n; i++) begin dn_n = 0; tick(); dn_n = 1; tick(); end
   endtask

   task automatic do_clear();
      clr_n = 0; tick(); clr_n = 1; tick();
   endtask

   task automatic test_reset();
      rst_n = 0;
      for (int i = 0; i < 4; i++) begin up_n = ~up_n; tick(); end
      up_n = 1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (obs(k) !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state dut%0d got=%h want=%h", k, obs(k), {8'h00, 4'b0100});
         end
      end
      rst_n = 1; tick();
      up_n = 0; tick();
      n_checks++;
      if (d0 !== 8'h01 || d1 !== 8'h01) begin
         n_fail++;
         $display("FAIL first_up got=%h/%h want=01/01", d0, d1);
      end
      up_n = 1; tick();
   endtask

   task automatic test_hold_carry();
      do_clear();
      up_n = 0;
      for (int i = 0; i < 20; i++) tick();
      up_n = 1; tick();
      n_checks++;
      if (d0 !== 8'h01 || d1 !== 8'h01) begin
         n_fail++;
         $display("FAIL hold_once got=%h/%h want=01/01", d0, d1);
      end
      do_clear();
      pulse_up(10);
      n_checks++;
      if (d0 !== 8'h10 || d1 !== 8'h10) begin
         n_fail++;
         $display("FAIL carry_10 got=%h/%h want=10/10", d0, d1);
      end
      pulse_dn(1);
      n_checks++;
      if (d0 !== 8'h09 || d1 !== 8'h09) begin
         n_fail++;
         $display("FAIL borrow_09 got=%h/%h want=09/09", d0, d1);
      end
   endtask

   task automatic test_saturate();
      do_clear();
      pulse_up(99);
      n_checks++;
      if ({d0, mx0, ov0} !== {8'h99, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL sat_reach99 got=%h max=%b ov=%b want=99 max=1 ov=0", d0, mx0, ov0);
      end
      pulse_up(1);
      n_checks++;
      if ({d0, mx0, ov0} !== {8'h99, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL sat_over got=%h max=%b ov=%b want=99 max=1 ov=1", d0, mx0, ov0);
      end
      n_checks++;
      if (obs(1) !== expv(1)) begin
         n_fail++;
         $display("FAIL wrap_during_sat got=%h want=%h", obs(1), expv(1));
      end
      pulse_dn(3);
      n_checks++;
      if ({d0, ov0} !== {8'h96, 1'b1}) begin
         n_fail++;
         $display("FAIL sticky_ov got=%h ov=%b want=96 ov=1", d0, ov0);
      end
      do_clear();
      pulse_dn(1);
      n_checks++;
      if ({d0, z0, un0, ov0} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL sat_under got=%h z=%b un=%b ov=%b want=00 1 1 0", d0, z0, un0, ov0);
      end
      clr_n = 0; tick();
      n_checks++;
      if ({ov0, un0, ov1, un1} !== 4'b0000) begin
         n_fail++;
         $display("FAIL clear_flags got=%b want=0000", {ov0, un0, ov1, un1});
      end
      clr_n = 1; tick();
   endtask

   task automatic test_wrap();
      do_clear();
      pulse_up(59);
      n_checks++;
      if ({d1, mx1} !== {8'h59, 1'b1}) begin
         n_fail++;
         $display("FAIL wrap_reach59 got=%h max=%b want=59 max=1", d1, mx1);
      end
      pulse_up(1);
      n_checks++;
      if ({d1, ov1, un1} !== {8'h00, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL wrap_over got=%h ov=%b un=%b want=00 1 0", d1, ov1, un1);
      end
      pulse_dn(1);
      n_checks++;
      if ({d1, ov1, un1} !== {8'h59, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL wrap_under got=%h ov=%b un=%b want=59 1 1", d1, ov1, un1);
      end
      n_checks++;
      if (d0 !== bcd(mv[0])) begin
         n_fail++;
         $display("FAIL sat_during_wrap got=%h want=%h", d0, bcd(mv[0]));
      end
   endtask

   task automatic test_priority();
      do_clear();
      pulse_up(42);
      up_n = 0; dn_n = 0; tick();
      up_n = 1; dn_n = 1; tick();
      n_checks++;
      if (d0 !== 8'h42 || d1 !== bcd(mv[1])) begin
         n_fail++;
         $display("FAIL cancel got=%h/%h want=42/%h", d0, d1, bcd(mv[1]));
      end
      clr_n = 0; up_n = 0; tick();
      n_checks++;
      if (d0 !== 8'h00 || d1 !== 8'h00) begin
         n_fail++;
         $display("FAIL clear_beats_up got=%h/%h want=00/00", d0, d1);
      end
      tick();
      clr_n = 1; tick(); tick();
      n_checks++;
      if (d0 !== 8'h00 || d1 !== 8'h00) begin
         n_fail++;
         $display("FAIL held_through_clear got=%h/%h want=00/00", d0, d1);
      end
      up_n = 1; tick();
   endtask

   task automatic test_reset_midcount();
      do_clear();
      pulse_up(37);
      dn_n = 0; up_n = 0; tick(); dn_n = 1; up_n = 1; tick();
      up_n = 0; rst_n = 0; tick();
      n_checks++;
      if ({d0, ov0, un0, d1, ov1, un1} !== {8'h00, 2'b00, 8'h00, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_mid got=%h %b%b %h %b%b want=00 00 00 00", d0, ov0, un0, d1, ov1, un1);
      end
      // Request still low after release: history reset to 1 means it counts.
      rst_n = 1; tick();
      n_checks++;
      if (d0 !== 8'h01 || d1 !== 8'h01) begin
         n_fail++;
         $display("FAIL reset_prev_high got=%h/%h want=01/01", d0, d1);
      end
      up_n = 1; tick();
   endtask

   task automatic test_random();
      int bias;
      bias = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 300 == 0) bias = $urandom_range(20, 80);
         rst_n = ($urandom_range(0, 199) != 0);
         clr_n = ($urandom_range(0, 99) != 0);
         up_n  = ($urandom_range(0, 99) >= bias);
         dn_n  = ($urandom_range(0, 99) <  bias);
         tick();
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== expv(k)) begin
               n_fail++;
               $display("FAIL random dut%0d cyc=%0d got=%h want=%h", k, i, obs(k), expv(k));
            end
         end
      end
      rst_n = 1; clr_n = 1; up_n = 1; dn_n = 1; tick();
   endtask

   initial begin
      test_reset();
      test_hold_carry();
      test_saturate();
      test_wrap();
      test_priority();
      test_reset_midcount();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
